fp_addsub_sequencer: RTL and testbench

// Sequencing controller for the 23-bit mantissa adder (fullAdder32) in the FP calculator.

---
 rtl/fp_addsub_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 tb/tb_fp_addsub_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_sequencer.sv
// fp_addsub_sequencer
//   Sequences one IEEE-754 single-precision add/subtract through an external
//   23-bit mantissa adder. The block unpacks both operands and orders them by
//   magnitude. It aligns the smaller operand, runs the adder through its
//   load/enable handshake, normalizes the sum and packs the result. Rounding
//   truncates. Denormal inputs and outputs are flushed to zero.
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   start     operation request, sampled only while idle
//   op        0 = A+B, 1 = A-B
//   a_in      operand A (IEEE-754 single)
//   b_in      operand B (IEEE-754 single)
//   busy      high whenever the sequencer is not idle
//   done      one-cycle pulse, result valid while high
//   result    packed result, held until the next done
//   add_en    adder enable
//   add_load  adder load strobe
//   add_pm    adder op, 1 = effective subtract
//   add_a     aligned fraction of the larger operand
//   add_b     aligned fraction of the smaller operand
//   add_ua    hidden bit of the larger operand
//   add_ub    hidden bit of the smaller operand after alignment
//   add_sum   adder sum
//   add_cout  adder carry-out (no-borrow flag when subtracting)

module fp_addsub_sequencer #(
    parameter int unsigned ADD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        add_en,
    output logic        add_load,
    output logic        add_pm,
    output logic [22:0] add_a,
    output logic [22:0] add_b,
    output logic        add_ua,
    output logic        add_ub,
    input  logic [22:0] add_sum,
    input  logic        add_cout
);

    localparam int unsigned RunW = (ADD_CYCLES > 2) ? $clog2(ADD_CYCLES) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StSort,
        StAlign,
        StLoad,
        StRun,
        StCapt,
        StNorm,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Latched operands (B sign already folded with op)
    logic        sa_q, sa_d, sb_q, sb_d;
    logic [7:0]  ea_q, ea_d, eb_q, eb_d;
    logic [22:0] fa_q, fa_d, fb_q, fb_d;

    // Ordered datapath
    logic               sign_q, sign_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [22:0]        lfrac_q, lfrac_d;
    logic               lhid_q, lhid_d;
    logic [23:0]        sm_q, sm_d;
    logic               eff_sub_q, eff_sub_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [RunW-1:0]    run_cnt_q, run_cnt_d;
    logic [24:0]        mag_q, mag_d;
    logic               special_q, special_d;

    // Registered outputs
    logic        busy_q, busy_d, done_q, done_d;
    logic [31:0] result_q, result_d;
    logic        add_en_q, add_en_d, add_load_q, add_load_d, add_pm_q, add_pm_d;
    logic [22:0] add_a_q, add_a_d, add_b_q, add_b_d;
    logic        add_ua_q, add_ua_d, add_ub_q, add_ub_d;

    // Unpack with zero-exponent flush, and order by {exp,frac}
    logic        hid_a, hid_b, a_ge_b;
    logic [22:0] frac_a, frac_b;
    logic [7:0]  exp_l, exp_s, exp_diff;
    logic [4:0]  shift_amt;

    assign hid_a     = (ea_q != 8'd0);
    assign hid_b     = (eb_q != 8'd0);
    assign frac_a    = hid_a ? fa_q : 23'd0;
    assign frac_b    = hid_b ? fb_q : 23'd0;
    assign a_ge_b    = ({ea_q, frac_a} >= {eb_q, frac_b});
    assign exp_l     = a_ge_b ? ea_q : eb_q;
    assign exp_s     = a_ge_b ? eb_q : ea_q;
    assign exp_diff  = exp_l - exp_s;
    // Past 25 shifts the smaller operand is already all zeros
    assign shift_amt = (exp_diff > 8'd25) ? 5'd25 : exp_diff[4:0];

    // Capture: rebuild the two integer bits above the 23-bit adder sum
    logic [1:0]  hi_add, hi_sub;
    logic [24:0] mag_capt;

    assign hi_add   = {1'b0, add_ua_q} + {1'b0, add_ub_q} + {1'b0, add_cout};
    assign hi_sub   = {1'b0, add_ua_q} - {1'b0, add_ub_q} - {1'b0, ~add_cout};
    assign mag_capt = {(add_pm_q ? hi_sub : hi_add), add_sum};

    function automatic logic [31:0] pack_result(
        input logic              special,
        input logic              is_zero,
        input logic              sign,
        input logic signed [9:0] e,
        input logic [22:0]       frac
    );
        if (special) begin
            pack_result = 32'h7FC0_0000;
        end else if (is_zero) begin
            pack_result = 32'h0000_0000;
        end else if (e >= 10'sd255) begin
            pack_result = {sign, 8'hFF, 23'd0};
        end else if (e <= 10'sd0) begin
            pack_result = {sign, 31'd0};
        end else begin
            pack_result = {sign, e[7:0], frac};
        end
    endfunction

    always_comb begin
        state_d    = state_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        ea_d       = ea_q;
        eb_d       = eb_q;
        fa_d       = fa_q;
        fb_d       = fb_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        lfrac_d    = lfrac_q;
        lhid_d     = lhid_q;
        sm_d       = sm_q;
        eff_sub_d  = eff_sub_q;
        cnt_d      = cnt_q;
        run_cnt_d  = run_cnt_q;
        mag_d      = mag_q;
        special_d  = special_q;
        result_d   = result_q;
        add_pm_d   = add_pm_q;
        add_a_d    = add_a_q;
        add_b_d    = add_b_q;
        add_ua_d   = add_ua_q;
        add_ub_d   = add_ub_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StSort;
                    sa_d      = a_in[31];
                    ea_d      = a_in[30:23];
                    fa_d      = a_in[22:0];
                    sb_d      = b_in[31] ^ op;
                    eb_d      = b_in[30:23];
                    fb_d      = b_in[22:0];
                    special_d = 1'b0;
                end
            end
            StSort: begin
                special_d = (ea_q == 8'hFF) || (eb_q == 8'hFF);
                if (special_d) begin
                    // Special operands skip the adder; NORM idles one cycle
                    state_d = StNorm;
                end else begin
                    sign_d    = a_ge_b ? sa_q : sb_q;
                    exp_d     = {2'b00, exp_l};
                    lfrac_d   = a_ge_b ? frac_a : frac_b;
                    lhid_d    = a_ge_b ? hid_a : hid_b;
                    sm_d      = a_ge_b ? {hid_b, frac_b} : {hid_a, frac_a};
                    eff_sub_d = sa_q ^ sb_q;
                    cnt_d     = shift_amt;
                    state_d   = (shift_amt != 5'd0) ? StAlign : StLoad;
                end
            end
            StAlign: begin
                sm_d  = sm_q >> 1;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                run_cnt_d = RunW'(ADD_CYCLES - 1);
                state_d   = StRun;
            end
            StRun: begin
                if (run_cnt_q == '0) begin
                    state_d = StCapt;
                end else begin
                    run_cnt_d = run_cnt_q - 1'b1;
                end
            end
            StCapt: begin
                mag_d = mag_capt;
                if (mag_capt == 25'd0) begin
                    state_d = StDone;
                end else if (mag_capt[24] || !mag_capt[23]) begin
                    state_d = StNorm;
                end else begin
                    state_d = StDone;
                end
            end
            StNorm: begin
                if (special_q) begin
                    state_d = StDone;
                end else if (mag_q[24]) begin
                    mag_d   = mag_q >> 1;
                    exp_d   = exp_q + 10'sd1;
                    state_d = StDone;
                end else begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - 10'sd1;
                    if (mag_q[22]) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered from the next state
        busy_d     = (state_d != StIdle);
        done_d     = (state_d == StDone);
        add_en_d   = (state_d == StLoad) || (state_d == StRun);
        add_load_d = (state_d == StLoad);

        // Operand ports are set on entry to LOAD and hold through CAPT
        if (state_d == StLoad) begin
            add_a_d  = lfrac_d;
            add_b_d  = sm_d[22:0];
            add_ua_d = lhid_d;
            add_ub_d = sm_d[23];
            add_pm_d = eff_sub_d;
        end

        if (state_d == StDone) begin
            result_d = pack_result(special_d, (mag_d == 25'd0), sign_d, exp_d, mag_d[22:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            ea_q       <= 8'd0;
            eb_q       <= 8'd0;
            fa_q       <= 23'd0;
            fb_q       <= 23'd0;
            sign_q     <= 1'b0;
            exp_q      <= 10'sd0;
            lfrac_q    <= 23'd0;
            lhid_q     <= 1'b0;
            sm_q       <= 24'd0;
            eff_sub_q  <= 1'b0;
            cnt_q      <= 5'd0;
            run_cnt_q  <= '0;
            mag_q      <= 25'd0;
            special_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= 32'd0;
            add_en_q   <= 1'b0;
            add_load_q <= 1'b0;
            add_pm_q   <= 1'b0;
            add_a_q    <= 23'd0;
            add_b_q    <= 23'd0;
            add_ua_q   <= 1'b0;
            add_ub_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            ea_q       <= ea_d;
            eb_q       <= eb_d;
            fa_q       <= fa_d;
            fb_q       <= fb_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            lfrac_q    <= lfrac_d;
            lhid_q     <= lhid_d;
            sm_q       <= sm_d;
            eff_sub_q  <= eff_sub_d;
            cnt_q      <= cnt_d;
            run_cnt_q  <= run_cnt_d;
            mag_q      <= mag_d;
            special_q  <= special_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            add_en_q   <= add_en_d;
            add_load_q <= add_load_d;
            add_pm_q   <= add_pm_d;
            add_a_q    <= add_a_d;
            add_b_q    <= add_b_d;
            add_ua_q   <= add_ua_d;
            add_ub_q   <= add_ub_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign add_en   = add_en_q;
    assign add_load = add_load_q;
    assign add_pm   = add_pm_q;
    assign add_a    = add_a_q;
    assign add_b    = add_b_q;
    assign add_ua   = add_ua_q;
    assign add_ub   = add_ub_q;

endmodule

// File: tb/tb_fp_addsub_sequencer.sv
// Directed-vector bench for fp_addsub_sequencer with a behavioural mantissa
// adder: operands load on add_en&add_load, sum/carry update on add_en alone.

module tb_fp_addsub_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a_in = 32'd0;
    logic [31:0] b_in = 32'd0;
    logic        busy, done, add_en, add_load, add_pm, add_ua, add_ub;
    logic [31:0] result;
    logic [22:0] add_a, add_b;
    logic [22:0] add_sum = 23'd0;
    logic        add_cout = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fp_addsub_sequencer #(.ADD_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .add_en   (add_en),
        .add_load (add_load),
        .add_pm   (add_pm),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_ua   (add_ua),
        .add_ub   (add_ub),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // Mantissa adder model; subtract is a + ~b + 1 so cout means "no borrow"
    logic [22:0] m_a = 23'd0, m_b = 23'd0;
    logic        m_pm = 1'b0;
    always @(posedge clk) begin
        if (add_en) begin
            if (add_load) begin
                m_a  <= add_a;
                m_b  <= add_b;
                m_pm <= add_pm;
            end else if (m_pm) begin
                {add_cout, add_sum} <= {1'b0, m_a} + {1'b0, ~m_b} + 24'd1;
            end else begin
                {add_cout, add_sum} <= {1'b0, m_a} + {1'b0, m_b};
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation, count edges from the start-sampling edge to done
    task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic o, input logic [31:0] exp_res, input int exp_lat,
                           input logic exp_en, input logic glitch);
        int   lat;
        logic saw_en;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        op    = o;
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        lat    = 0;
        saw_en = 1'b0;
        check({tag, ".busy"}, {31'd0, busy}, 32'd1);
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (add_en === 1'b1) saw_en = 1'b1;
            if (glitch && lat == 2) begin
                a_in  = 32'h3F80_0000;
                b_in  = 32'h3F80_0000;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".result"}, result, exp_res);
        check({tag, ".add_en_seen"}, {31'd0, saw_en}, {31'd0, exp_en});
        // start during the done cycle must be ignored
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, ".idle_after"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.done", {31'd0, done}, 32'd0);
        check("rst.result", result, 32'd0);
        check("rst.ctl", {29'd0, add_en, add_load, add_pm}, 32'd0);
        check("rst.ops", {7'd0, add_ua, add_ub, add_a}, 32'd0);
        check("rst.opb", {9'd0, add_b}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_vec("one_plus_one",   32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 8,  1'b1, 1'b0);
        run_vec("three_minus_one",32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 8,  1'b1, 1'b0);
        run_vec("d24_truncate",   32'h4B80_0000, 32'h3F80_0000, 1'b0, 32'h4B80_0000, 31, 1'b1, 1'b0);
        run_vec("start_ignored",  32'h4040_0000, 32'h3F80_0000, 1'b0, 32'h4080_0000, 9,  1'b1, 1'b1);
        run_vec("neg_plus_pos",   32'hBF80_0000, 32'h4000_0000, 1'b0, 32'h3F80_0000, 9,  1'b1, 1'b0);
        run_vec("overflow_inf",   32'h7F00_0000, 32'h7F00_0000, 1'b0, 32'h7F80_0000, 8,  1'b1, 1'b0);
        run_vec("denorm_flush",   32'h0040_0000, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 32, 1'b1, 1'b0);
        run_vec("underflow_zero", 32'h00C0_0000, 32'h0080_0000, 1'b1, 32'h0000_0000, 8,  1'b1, 1'b0);
        run_vec("inf_a",          32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 2,  1'b0, 1'b0);
        run_vec("nan_b",          32'h3F80_0000, 32'h7F80_0001, 1'b1, 32'h7FC0_0000, 2,  1'b0, 1'b0);
        run_vec("equal_cancel",   32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 7,  1'b1, 1'b0);

        // Abort an operation in RUN with reset
        @(negedge clk);
        a_in  = 32'h3F80_0000;
        b_in  = 32'h3F80_0000;
        op    = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort.in_run", {30'd0, add_en, add_load}, 32'd2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort.busy", {31'd0, busy}, 32'd0);
        check("abort.add_en", {31'd0, add_en}, 32'd0);
        check("abort.done", {31'd0, done}, 32'd0);
        check("abort.result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_vec("after_abort",    32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 8,  1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
